// File: rtl/demux_1ton_reg.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per lane.
// Ports: clk, rst (sync, active high), in_data/in_sel/in_valid/in_ready (input stream),
//        out_data/out_valid/out_ready (N lanes), drop_err/drop_cnt (out-of-range select).
module demux_1ton_reg #(
   parameter int N     = 2,
   parameter int WIDTH = 8,
   parameter int SELW  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SELW-1:0]    in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready,
   output logic               drop_err,
   output logic [7:0]         drop_cnt
);

   logic in_range;
   logic sel_free;
   logic accept;

   // Lane lookup by loop so an out-of-range in_sel never indexes past N.
   always_comb begin
      in_range = (int'(in_sel) < N);
      sel_free = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (int'(in_sel) == k) begin
            sel_free = !out_valid[k] | out_ready[k];
         end
      end
   end

   // Out-of-range words are always taken so they can be discarded.
   assign in_ready = !rst & (in_range ? sel_free : 1'b1);
   assign accept   = in_valid & in_ready;

   // Load wins over drain: a same-cycle load+drain is a replace.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (accept && int'(in_sel) == k) begin
               out_data[k*WIDTH +: WIDTH] <= in_data;
               out_valid[k]               <= 1'b1;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_err <= 1'b0;
         drop_cnt <= '0;
      end else begin
         drop_err <= accept & !in_range;
         if (accept && !in_range && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_demux_1ton_reg.sv
// Directed bench for demux_1ton_reg (N=2, WIDTH=8) with a per-lane scoreboard.
// Ports: drives every DUT port; checks each cycle half a period after the edge.
module tb_demux_1ton_reg;

   localparam int N = 2;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic [3:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0] out_valid;
   logic [N-1:0] out_ready;
   logic         drop_err;
   logic [7:0]   drop_cnt;

   demux_1ton_reg #(.N(N), .WIDTH(W), .SELW(4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready),
      .drop_err(drop_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] q [N][$];
   logic [W-1:0] last [N];
   logic         m_derr;
   logic [7:0]   m_dcnt;
   bit           init = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v,
                        input logic [3:0] s,
                        input logic [W-1:0] d,
                        input logic [N-1:0] ordy);
      logic m_rdy;
      logic acc;
      logic [W-1:0] exp_w;
      rst       = r;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = ordy;
      #1;
      if (r) m_rdy = 1'b0;
      else if (int'(s) >= N) m_rdy = 1'b1;
      else m_rdy = (q[s].size() == 0) || ordy[s];
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
      if (init) begin
         for (int k = 0; k < N; k++) begin
            chk($sformatf("valid%0d", k), {31'd0, out_valid[k]},
                {31'd0, q[k].size() != 0});
            chk($sformatf("data%0d", k), {24'd0, out_data[k*W +: W]},
                {24'd0, last[k]});
         end
         chk("drop_err", {31'd0, drop_err}, {31'd0, m_derr});
         chk("drop_cnt", {24'd0, drop_cnt}, {24'd0, m_dcnt});
      end
      if (r) begin
         for (int k = 0; k < N; k++) begin
            q[k].delete();
            last[k] = '0;
         end
         m_derr = 1'b0;
         m_dcnt = '0;
         init   = 1;
      end else begin
         acc = v & m_rdy;
         for (int k = 0; k < N; k++) begin
            if (q[k].size() != 0 && ordy[k]) begin
               exp_w = q[k].pop_front();
               chk($sformatf("drain%0d", k),
                   {24'd0, out_data[k*W +: W]}, {24'd0, exp_w});
            end
            if (acc && int'(s) == k) begin
               q[k].push_back(d);
               last[k] = d;
            end
         end
         m_derr = acc && int'(s) >= N;
         if (m_derr && m_dcnt != 8'hff) m_dcnt = m_dcnt + 8'd1;
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // reset with in_valid high
      repeat (3) drive(1, 1, 0, 8'hff, 2'b11);
      // basic routing
      drive(0, 1, 0, 8'ha5, 2'b11);
      drive(0, 1, 1, 8'h3c, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      // backpressure on lane 0
      drive(0, 1, 0, 8'h11, 2'b10);
      drive(0, 1, 0, 8'h22, 2'b10);
      drive(0, 1, 0, 8'h22, 2'b10);
      drive(0, 1, 1, 8'h33, 2'b10);
      drive(0, 1, 0, 8'h22, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      // streaming lane 1
      for (int i = 0; i < 8; i++)
         drive(0, 1, 1, 8'h40 + 8'(i), 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      // bad selects
      drive(0, 1, 2, 8'hde, 2'b11);
      drive(0, 1, 15, 8'had, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      for (int i = 0; i < 300; i++)
         drive(0, 1, 4'(2 + (i % 14)), 8'(i), 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      // reset while lane 0 full and stalled
      drive(0, 1, 0, 8'h77, 2'b00);
      drive(0, 0, 0, 8'h00, 2'b00);
      drive(1, 0, 0, 8'h00, 2'b00);
      drive(0, 1, 0, 8'h88, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      drive(0, 0, 0, 8'h00, 2'b11);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
